match_sequencer: RTL

- Top-level point/match state machine for the pong game.
- Gates `game_on` to both paddle instances (human and computer player) and the ball engine.
- Issues one-cycle serve requests, keeps both scores, inserts a timed pause between points, detects the winner, and latches the computer-player difficulty at match start.
- Sits between the button/ball-miss event sources and the paddle and ball datapaths.

---
 rtl/match_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/match_sequencer.sv
// Point/match sequencer for pong: gates game_on, serves, scores, pause, winner.
// Ports: clk/reset, start/pause/miss buttons, diff_sel in;
//        game_on, serve_req, serve_dir, scores, winner, diff_out, state out.
// Optional: define AUTO_DIFF_EN to bump difficulty when the left side leads by 2+.
module match_sequencer #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned PAUSE_TICKS = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic [1:0] diff_sel,
  output logic       game_on,
  output logic       serve_req,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [1:0] diff_out,
  output logic [2:0] state
);
  localparam int unsigned TW =
    (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(PAUSE_TICKS - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    RALLY  = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          game_on_q, game_on_d;
  logic          serve_req_q, serve_req_d;
  logic          serve_dir_q, serve_dir_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic [1:0]    winner_q, winner_d;
  logic [1:0]    diff_q, diff_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_p_q, pause_p_q, ml_p_q, mr_p_q;

  logic start_e, pause_e, ml_e, mr_e;

  assign start_e = start_btn & ~start_p_q;
  assign pause_e = pause_btn & ~pause_p_q;
  assign ml_e    = miss_left & ~ml_p_q;
  assign mr_e    = miss_right & ~mr_p_q;

  always_comb begin
    state_d     = state_q;
    serve_dir_d = serve_dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    diff_d      = diff_q;
    timer_d     = timer_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_e) begin
          diff_d      = diff_sel;
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          state_d     = SERVE;
        end
      end
      SERVE: state_d = RALLY;
      RALLY: begin
        if (ml_e && mr_e) begin
          // Simultaneous misses replay the point.
          state_d = POINT;
          timer_d = TLOAD;
        end else if (ml_e || mr_e) begin
          if (ml_e) begin
            score_r_d   = score_r_q + 4'd1;
            serve_dir_d = 1'b0;
          end else begin
            score_l_d   = score_l_q + 4'd1;
            serve_dir_d = 1'b1;
          end
          if (score_r_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else if (score_l_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d = POINT;
            timer_d = TLOAD;
`ifdef AUTO_DIFF_EN
            if (diff_q != 2'b00 && diff_q != 2'b11 &&
                {1'b0, score_l_d} >= {1'b0, score_r_d} + 5'd2)
              diff_d = diff_q + 2'd1;
`endif
          end
        end else if (pause_e) begin
          state_d = PAUSED;
        end
      end
      POINT: begin
        if (timer_q == '0) state_d = SERVE;
        else timer_d = timer_q - TW'(1);
      end
      PAUSED: if (pause_e) state_d = RALLY;
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they are registered.
    game_on_d   = (state_d == SERVE) || (state_d == RALLY);
    serve_req_d = (state_d == SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      game_on_q   <= 1'b0;
      serve_req_q <= 1'b0;
      serve_dir_q <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 2'b00;
      diff_q      <= 2'b01;
      timer_q     <= '0;
      start_p_q   <= 1'b0;
      pause_p_q   <= 1'b0;
      ml_p_q      <= 1'b0;
      mr_p_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      game_on_q   <= game_on_d;
      serve_req_q <= serve_req_d;
      serve_dir_q <= serve_dir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      diff_q      <= diff_d;
      timer_q     <= timer_d;
      start_p_q   <= start_btn;
      pause_p_q   <= pause_btn;
      ml_p_q      <= miss_left;
      mr_p_q      <= miss_right;
    end
  end

  assign game_on     = game_on_q;
  assign serve_req   = serve_req_q;
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;
  assign diff_out    = diff_q;
  assign state       = state_q;
endmodule
